sipo_frame_loader: RTL
======================

Name: sipo_frame_loader

Overview:
- Serial-to-parallel front end: assembles a WIDTH-bit word from a gated serial bit stream.
- Presents the word on a stable parallel bus and issues a one-cycle load strobe.
- Sits directly upstream of the 4-bit PIPO register: data drives its data input, load drives its load input.
- Internal shift register is kept separate from the output bus, so the bus never shows partial words.

Parameters:
- WIDTH, 4, number of data bits per frame; legal range 2..16.
- MSB_FIRST, 1, 1 = first received bit lands in data[WIDTH-1]; 0 = first received bit lands in data[0].

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame start request; sampled every cycle.
- din  input  1  serial data bit.
- din_valid  input  1  din is consumed on this edge when high and state is SHIFT.
- data  output  WIDTH  last completed word; registered.
- load  output  1  one-cycle strobe; high while data holds a newly completed word.
- busy  output  1  high while state is SHIFT.
- parity_err  output  1  one-cycle strobe on parity failure; tied 0 without PARITY_CHECK_EN.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE, bit counter=0, shift register=0.
  - data=0, load=0, busy=0, parity_err=0.
  - Reset overrides start and din_valid in the same cycle.
  - Reset during SHIFT discards the partial frame.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT, counter=0, shift register cleared.
  - din is not sampled on the start cycle.
- SHIFT:
  - Each edge with din_valid=1 shifts din in and increments the counter.
  - MSB_FIRST=1: shift left, din enters bit 0.
  - MSB_FIRST=0: shift right, din enters bit WIDTH-1.
  - din_valid=0 holds all state; gaps of any length are allowed.
  - start=1 in SHIFT restarts the frame: counter=0, shift register cleared, the din on that cycle is ignored, state stays SHIFT.
  - When the accepted bit count reaches FRAME_LEN, go to DONE on that same edge. FRAME_LEN = WIDTH, or WIDTH+1 with parity.
- DONE (exactly one cycle):
  - On the edge entering DONE, data <= assembled word and load <= 1.
  - Next edge: load <= 0, state -> IDLE.
  - start in the DONE cycle is ignored; start must be reissued from IDLE.
- Latency: load is high in the cycle immediately after the edge that accepted the last frame bit.
- data holds its value until the next successful frame completes.
- Between frames, load=0 and data is stable.
- busy is 1 in SHIFT only; it is 0 in IDLE and DONE.
- Counter width is clog2(WIDTH+2). The counter never wraps, because FRAME_LEN is checked before increment overflow.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each frame carries WIDTH data bits followed by one even-parity bit; FRAME_LEN = WIDTH+1.
  - The parity bit is not shifted into the data word.
  - At frame end, compute the XOR of the data bits and the parity bit.
  - XOR = 0: normal DONE behaviour.
  - XOR = 1: data unchanged, load stays 0, parity_err=1 for one cycle (the DONE cycle), then IDLE.
- Undefined:
  - FRAME_LEN = WIDTH, no parity bit is expected.
  - parity_err is constant 0.

Test Plan:
- Basic MSB-first, WIDTH=4:
  - Stimulus: reset, start, then din 1,0,1,1 with din_valid=1 each cycle.
  - Required: load=1 for exactly one cycle, the cycle after the 4th bit; data=4'b1011; busy=1 for 4 cycles; data still 4'b1011 ten cycles later.
- LSB-first, MSB_FIRST=0:
  - Stimulus: same bit sequence 1,0,1,1.
  - Required: data=4'b1101, one load pulse.
- Gapped input:
  - Stimulus: bits 0,1,1,0 with din_valid low for 3 cycles between every bit.
  - Required: data=4'b0110; load fires only after the 4th valid bit; no state change during gaps.
- Restart and reset mid-frame:
  - Stimulus: 2 bits, then start=1, then 1,1,1,1.
  - Required: data=4'b1111.
  - Second stimulus: a new frame with 2 bits, then reset.
  - Required: data=0, busy=0, no load pulse.
- Parity, PARITY_CHECK_EN defined:
  - Stimulus: 1,0,1,1 followed by parity 1.
  - Required: data=4'b1011, load pulse, parity_err=0.
  - Stimulus: 0,1,1,1 followed by parity 0.
  - Required: parity_err pulse, no load, data still 4'b1011.

Source files
------------

// File: rtl/sipo_frame_loader.sv
// Serial-to-parallel frame loader: shifts a gated serial stream into a WIDTH-bit word,
// then publishes it on a stable bus with a one-cycle load strobe. Optional macro: PARITY_CHECK_EN.
module sipo_frame_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] data,
  output logic             load,
  output logic             busy,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             load_reg, load_next;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
`ifdef PARITY_CHECK_EN
  logic             perr_reg, perr_next;
`endif

  always_comb begin
    if (MSB_FIRST) shifted = {shreg_reg[WIDTH-2:0], din};
    else           shifted = {din, shreg_reg[WIDTH-1:1]};
  end

  // The counter holds the number of bits already accepted, so this bit completes the frame.
  assign last_bit = (cnt_reg == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      data_reg  <= '0;
      load_reg  <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      data_reg  <= data_next;
      load_reg  <= load_next;
`ifdef PARITY_CHECK_EN
      perr_reg  <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shreg_next = shreg_reg;
    data_next  = data_reg;
    load_next  = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_next  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          cnt_next   = '0;
          shreg_next = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_next   = '0;
          shreg_next = '0;
        end else if (din_valid) begin
          if (last_bit) begin
            state_next = DONE;
            cnt_next   = '0;
`ifdef PARITY_CHECK_EN
            // Final bit is the even-parity bit; it is checked, never shifted into the word.
            if ((^shreg_reg) ^ din) begin
              perr_next = 1'b1;
            end else begin
              data_next = shreg_reg;
              load_next = 1'b1;
            end
`else
            shreg_next = shifted;
            data_next  = shifted;
            load_next  = 1'b1;
`endif
          end else begin
            shreg_next = shifted;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data = data_reg;
  assign load = load_reg;
  assign busy = (state_reg == SHIFT);
`ifdef PARITY_CHECK_EN
  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
